// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, blanking
// codes and the active-low hex segment table ({g,f,e,d,c,b,a}).
package seg7_pkg;

    localparam int unsigned NDIG = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low one-hot anode select for a digit index.
    function automatic logic [7:0] anode_sel(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low seven-segment code.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with guard interval, frame-aligned
// commit of written values and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned GUARD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        blank_lz,
    output logic        frame_sync,
    output logic [7:0]  Anode_Control,
    output logic [6:0]  Cathode_Control
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("seg7_scan_driver: DIV must be at least 2");
    end
    if (GUARD >= DIV) begin : g_bad_guard
        $error("seg7_scan_driver: GUARD must be less than DIV");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_q, disp_d;
    logic [31:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    cath_q, cath_d;
    logic          fs_q;

    logic          last_cnt;
    logic          wrap;
    logic          in_guard;
    logic          blank;
    logic [3:0]    nibble;
    logic [31:0]   above;
    logic [6:0]    seg;

    assign last_cnt = (cnt_q == CW'(DIV - 1));
    assign wrap     = last_cnt && (idx_q == 3'(NDIG - 1));

    // Scan counters and frame-aligned commit of the pending value.
    always_comb begin
        cnt_d    = last_cnt ? '0 : cnt_q + CW'(1);
        idx_d    = last_cnt ? idx_q + 3'd1 : idx_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        if (wr_en) begin
            pend_d = wr_data;
        end
        if (wrap) begin
            pend_v_d = 1'b0;
            if (wr_en) begin
                disp_d = wr_data;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
        end else if (wr_en) begin
            pend_v_d = 1'b1;
        end
    end

    assign nibble   = disp_q[{idx_q, 2'b00} +: 4];
    assign above    = disp_q >> {idx_q, 2'b00};
    assign in_guard = (cnt_q < CW'(GUARD));
    // Digit 0 is never blanked so a zero value still shows a single 0.
    assign blank    = blank_lz && (idx_q != 3'd0) && (above == 32'd0);

    seg7_hex_decoder u_dec (
        .nibble (nibble),
        .seg    (seg)
    );

    always_comb begin
        an_d   = AN_OFF;
        cath_d = SEG_OFF;
        if (!in_guard && !blank) begin
            an_d   = anode_sel(idx_q);
            cath_d = seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            disp_q   <= 32'd0;
            pend_q   <= 32'd0;
            pend_v_q <= 1'b0;
            an_q     <= AN_OFF;
            cath_q   <= SEG_OFF;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            an_q     <= an_d;
            cath_q   <= cath_d;
            fs_q     <= wrap;
        end
    end

    assign frame_sync      = fs_q;
    assign Anode_Control   = an_q;
    assign Cathode_Control = cath_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=8, GUARD=2 (64-cycle frame).
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        blank_lz;
    logic        frame_sync;
    logic [7:0]  Anode_Control;
    logic [6:0]  Cathode_Control;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_driver #(
        .DIV   (8),
        .GUARD (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .blank_lz        (blank_lz),
        .frame_sync      (frame_sync),
        .Anode_Control   (Anode_Control),
        .Cathode_Control (Cathode_Control)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, " an"}, 32'(Anode_Control), 32'h0000_00FF);
        check({tag, " ca"}, 32'(Cathode_Control), 32'h0000_007F);
        check({tag, " fs"}, 32'(frame_sync), 32'd0);
    endtask

    task automatic write(input logic [31:0] val);
        wr_en   = 1'b1;
        wr_data = val;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_sync(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (frame_sync === 1'b1) seen = 1'b1;
        end
        check({tag, " sync seen"}, 32'(seen), 32'd1);
    endtask

    // Called on the sample where frame_sync is high (or right after a reset edge):
    // the next 64 samples are slots 0..7, and the last one carries the next sync.
    task automatic expect_frame(input logic [31:0] val, input logic blz, input string tag);
        int   s;
        int   c;
        logic off;
        logic [7:0] e_an;
        logic [6:0] e_ca;
        blank_lz = blz;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            s    = (k - 1) / 8;
            c    = (k - 1) % 8;
            off  = (c < 2) || (blz && s > 0 && (val >> (4 * s)) == 32'd0);
            e_an = off ? 8'hFF : ~(8'd1 << s);
            e_ca = off ? 7'h7F : seg_tab[val[4*s +: 4]];
            check($sformatf("%s an s%0d c%0d", tag, s, c), 32'(Anode_Control), 32'(e_an));
            check($sformatf("%s ca s%0d c%0d", tag, s, c), 32'(Cathode_Control), 32'(e_ca));
            check($sformatf("%s fs k%0d", tag, k), 32'(frame_sync), (k == 64) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 32'd0;
        blank_lz = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_off($sformatf("reset c%0d", i));
        end
        rst = 1'b0;
        @(negedge clk);
        check_off("post release");

        wait_sync("init");
        expect_frame(32'h0000_0000, 1'b0, "zero");
        expect_frame(32'h0000_0000, 1'b1, "zero blz");

        write(32'h1234_5678);
        wait_sync("w1");
        expect_frame(32'h1234_5678, 1'b0, "12345678");

        write(32'h0000_00A5);
        wait_sync("w2");
        expect_frame(32'h0000_00A5, 1'b1, "A5 blz");

        blank_lz = 1'b0;
        repeat (10) @(negedge clk);
        write(32'hAAAA_AAAA);
        repeat (5) @(negedge clk);
        write(32'hFFFF_FFFF);
        wait_sync("w3");
        expect_frame(32'hFFFF_FFFF, 1'b0, "last wins");

        // Strobe lands exactly on the wrap edge.
        repeat (63) @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 32'h0000_0003;
        @(negedge clk);
        wr_en   = 1'b0;
        check("wrap wr fs", 32'(frame_sync), 32'd1);
        expect_frame(32'h0000_0003, 1'b0, "wrap bypass");

        write(32'h1234_5678);
        wait_sync("w5");
        repeat (20) @(negedge clk);
        write(32'h8765_4321);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_off("mid reset");
        rst = 1'b0;
        expect_frame(32'h0000_0000, 1'b0, "after rst");
        expect_frame(32'h0000_0000, 1'b0, "after rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
